// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared RV32I pipeline definitions: architectural width, instruction size and
// the fetch-to-decode entry type.
// -----------------------------------------------------------------------------
package riscv_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  // One buffered instruction together with the address it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

endpackage : riscv_pkg

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO, generic in depth and entry type. Flush empties it in one
// cycle and overrides any push/pop issued in the same cycle. The caller never
// pushes when full or pops when empty.
//
// Ports
//   clk_i, rstn_i : clock, asynchronous active-low reset
//   push_i/data_i : write an entry
//   pop_i         : drop the head entry
//   flush_i       : discard all entries
//   data_o        : head entry (only meaningful when !empty_o)
//   full_o        : DEPTH entries held
//   empty_o       : no entries held
//   count_o       : number of entries held, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic [31:0]
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   push_i,
  input  entry_t                 data_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output entry_t                 data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // values from before the edge, independent of process ordering.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  // NOTE: the storage array carries no reset; an entry is only ever read after
  // it was written, and the count/pointers (which are reset) decide validity.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule : fetch_fifo

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// RV32I instruction fetch. Owns the PC, issues word fetches over a
// req/gnt/rvalid memory port, buffers returned instructions with their PCs and
// hands them to decode over valid/ready. A redirect flushes buffered entries,
// marks every in-flight response as stale and restarts at the target.
//
// Ports
//   clk_i, rstn_i        : clock, asynchronous active-low reset
//   redirect_valid_i/pc_i: flush and restart at redirect_pc_i (bits [1:0] ignored)
//   imem_req_o/addr_o    : fetch request and word-aligned byte address
//   imem_gnt_i           : request accepted this cycle
//   imem_rvalid_i/rdata_i: in-order response
//   instr_valid_o        : decode entry valid
//   instr_o/pc_o         : head instruction and its PC (zero when empty)
//   instr_ready_i        : decode accepts the head entry
// -----------------------------------------------------------------------------
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            instr_valid_o,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] pc_o,
  input  logic            instr_ready_i
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   drop_q, drop_d;

  // Address queue: PCs of outstanding requests; its count is out_cnt.
  logic            aq_push, aq_pop;
  logic [XLEN-1:0] aq_head;
  logic            aq_full, aq_empty;
  logic [CW-1:0]   out_cnt;

  // Instruction buffer towards decode.
  logic            if_push, if_pop, if_flush;
  fetch_entry_t    if_wdata, if_head;
  logic            if_full, if_empty;
  logic [CW-1:0]   if_count;

  logic [CW:0]     credit_used;
  logic            fetch_fire;
  logic            resp_keep;

  // Credit check on registered counts only: a same-cycle decode pop does not
  // free a slot until the next cycle. Gating with rstn_i keeps req low while
  // reset is asserted, even though the counts already read zero.
  assign credit_used = {1'b0, out_cnt} + {1'b0, if_count};
  assign imem_req_o  = rstn_i && !redirect_valid_i
                       && (credit_used < (CW+1)'(FIFO_DEPTH));
  assign imem_addr_o = pc_q;
  assign fetch_fire  = imem_req_o && imem_gnt_i;

  // Every response retires one address-queue entry; only non-stale responses
  // outside a redirect cycle reach the buffer.
  assign aq_push   = fetch_fire;
  assign aq_pop    = imem_rvalid_i;
  assign resp_keep = imem_rvalid_i && !redirect_valid_i && (drop_q == '0);

  assign if_push  = resp_keep;
  assign if_wdata = '{pc: aq_head, instr: imem_rdata_i};
  assign if_flush = redirect_valid_i;
  assign if_pop   = instr_valid_o && instr_ready_i;

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    pc_d   = pc_q;
    drop_d = drop_q;
    if (redirect_valid_i) begin
      pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
      // out_cnt already includes responses marked stale by earlier redirects,
      // so all outstanding responses, minus the one retiring now, are stale.
      drop_d = out_cnt - CW'(imem_rvalid_i);
    end else begin
      if (fetch_fire) pc_d = pc_q + XLEN'(INSTR_BYTES);
      if (imem_rvalid_i && (drop_q != '0)) drop_d = drop_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pc_q   <= RESET_PC;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
    end
  end

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (logic [XLEN-1:0])
  ) u_addr_q (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (aq_push),
    .data_i  (pc_q),
    .pop_i   (aq_pop),
    .flush_i (1'b0),
    .data_o  (aq_head),
    .full_o  (aq_full),
    .empty_o (aq_empty),
    .count_o (out_cnt)
  );

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (fetch_entry_t)
  ) u_instr_q (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (if_push),
    .data_i  (if_wdata),
    .pop_i   (if_pop),
    .flush_i (if_flush),
    .data_o  (if_head),
    .full_o  (if_full),
    .empty_o (if_empty),
    .count_o (if_count)
  );

  // Flags implied by the credit rule and not needed for control here.
  logic unused_flags;
  assign unused_flags = ^{aq_full, aq_empty, if_full};

  assign instr_valid_o = !if_empty && !redirect_valid_i;
  // Zero the presented entry when empty so uninitialised storage never shows.
  assign instr_o       = if_empty ? 32'h0      : if_head.instr;
  assign pc_o          = if_empty ? XLEN'(0)   : if_head.pc;

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Directed bench for fetch_stage (RESET_PC=0x100, FIFO_DEPTH=4). A memory model
// answers granted fetches after a programmable latency with a fixed function of
// the address. Directed phases push the PCs decode must see into a scoreboard
// queue; a monitor pops and compares on every decode handshake.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rstn;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        instr_ready;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_i            (clk),
    .rstn_i           (rstn),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .imem_req_o       (imem_req),
    .imem_addr_o      (imem_addr),
    .imem_gnt_i       (imem_gnt),
    .imem_rvalid_i    (imem_rvalid),
    .imem_rdata_i     (imem_rdata),
    .instr_valid_o    (instr_valid),
    .instr_o          (instr),
    .pc_o             (pc),
    .instr_ready_i    (instr_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // ---------------- memory model ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
  } resp_t;

  resp_t       mem_q[$];
  logic [31:0] gnt_log[$];
  int          gnt_cyc[$];
  int          hs_cyc[$];
  logic [31:0] exp_q[$];
  int          cyc = 0;
  int          lat = 1;
  logic        gnt_en;
  logic [31:0] mon_exp;

  assign imem_gnt = gnt_en;

  // Grants are captured mid-cycle, responses are driven just after the edge.
  always @(negedge clk) begin
    if (!rstn) begin
      mem_q.delete();
    end else if (imem_req && imem_gnt) begin
      mem_q.push_back('{addr: imem_addr, due: cyc + lat});
      gnt_log.push_back(imem_addr);
      gnt_cyc.push_back(cyc);
    end
  end

  always @(posedge clk) begin
    #1;
    cyc++;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    if (rstn && mem_q.size() != 0 && mem_q[0].due == cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mem_q[0].addr);
      void'(mem_q.pop_front());
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rstn && instr_valid && instr_ready) begin
      hs_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL dec_unexpected: got pc %h, required no entry", pc);
      end else begin
        mon_exp = exp_q.pop_front();
        check("dec_pc", pc, mon_exp);
        check("dec_instr", instr, mem_word(mon_exp));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic reset_dut();
    rstn           = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    gnt_en         = 1'b1;
    step();
    step();
    gnt_log.delete();
    gnt_cyc.delete();
    hs_cyc.delete();
    exp_q.delete();
  endtask

  task automatic release_reset();
    step();
    rstn = 1'b1;
  endtask

  task automatic expect_seq(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    instr_ready = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- directed phases ----------------
  initial begin
    rstn           = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    gnt_en         = 1'b1;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;

    // Reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, RST_PC);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_pc", pc, 32'h0);

    // Boot: streaming one per cycle.
    lat = 1;
    reset_dut();
    release_reset();
    instr_ready = 1'b1;
    expect_seq(RST_PC, 12);
    @(negedge clk);
    check("boot_req", {31'b0, imem_req}, 32'd1);
    check("boot_addr", imem_addr, RST_PC);
    drain("boot_drain", 60);
    check("boot_lat", 32'(hs_cyc[0] - gnt_cyc[0]), 32'd2);
    for (int i = 1; i < 12; i++) begin
      check("boot_hs_gap", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'd1);
      check("boot_gnt_gap", 32'(gnt_cyc[i] - gnt_cyc[i-1]), 32'd1);
      check("boot_gnt_addr", gnt_log[i], RST_PC + 32'(4 * i));
    end

    // Backpressure: decode stalled for 10 cycles.
    reset_dut();
    release_reset();
    repeat (5) step();
    @(negedge clk);
    check("bp_head_mid", pc, RST_PC);
    repeat (5) step();
    @(negedge clk);
    check("bp_nreq", 32'(gnt_log.size()), 32'd4);
    check("bp_req_off", {31'b0, imem_req}, 32'd0);
    check("bp_valid", {31'b0, instr_valid}, 32'd1);
    check("bp_head_pc", pc, RST_PC);
    check("bp_head_instr", instr, mem_word(RST_PC));
    for (int i = 0; i < 4; i++) check("bp_gnt_addr", gnt_log[i], RST_PC + 32'(4 * i));
    step();
    instr_ready = 1'b1;
    expect_seq(RST_PC, 8);
    drain("bp_drain", 60);
    check("bp_resumed", {31'b0, gnt_log.size() >= 8}, 32'd1);

    // Redirect with two responses in flight (latency 3).
    lat = 3;
    reset_dut();
    release_reset();
    instr_ready = 1'b1;
    expect_seq(32'h0000_2000, 4);
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_2002;
    @(negedge clk);
    check("rd_req_blocked", {31'b0, imem_req}, 32'd0);
    check("rd_valid_blocked", {31'b0, instr_valid}, 32'd0);
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("rd_req", {31'b0, imem_req}, 32'd1);
    check("rd_addr", imem_addr, 32'h0000_2000);
    drain("rd_drain", 60);
    check("rd_gnt_target", gnt_log[2], 32'h0000_2000);

    // Redirect coinciding with a response (latency 2).
    lat = 2;
    reset_dut();
    release_reset();
    instr_ready = 1'b1;
    expect_seq(32'h0000_3000, 4);
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_3000;
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("rc_addr", imem_addr, 32'h0000_3000);
    check("rc_valid_a", {31'b0, instr_valid}, 32'd0);
    step();
    @(negedge clk);
    check("rc_valid_b", {31'b0, instr_valid}, 32'd0);
    drain("rc_drain", 60);

    // Back-to-back redirects: the last target wins (latency 3).
    lat = 3;
    reset_dut();
    release_reset();
    instr_ready = 1'b1;
    expect_seq(32'h0000_6004, 4);
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_5000;
    step();
    redirect_pc    = 32'h0000_6007;
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("bb_addr", imem_addr, 32'h0000_6004);
    drain("bb_drain", 60);

    // Grant stall for 5 cycles.
    lat = 1;
    reset_dut();
    gnt_en = 1'b0;
    release_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("gs_req", {31'b0, imem_req}, 32'd1);
      check("gs_addr_hold", imem_addr, RST_PC);
      step();
    end
    gnt_en = 1'b1;
    @(negedge clk);
    check("gs_addr_grant", imem_addr, RST_PC);
    step();
    @(negedge clk);
    check("gs_addr_next", imem_addr, RST_PC + 32'd4);
    instr_ready = 1'b1;
    expect_seq(RST_PC, 4);
    drain("gs_drain", 60);

    // Asynchronous reset with a full buffer.
    lat = 1;
    reset_dut();
    release_reset();
    repeat (8) step();
    @(negedge clk);
    check("ar_full_valid", {31'b0, instr_valid}, 32'd1);
    check("ar_full_req", {31'b0, imem_req}, 32'd0);
    check("ar_pre_addr", imem_addr, RST_PC + 32'd16);
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    check("ar_valid_drop", {31'b0, instr_valid}, 32'd0);
    check("ar_req_low", {31'b0, imem_req}, 32'd0);
    check("ar_addr_reset", imem_addr, RST_PC);
    step();
    gnt_log.delete();
    gnt_cyc.delete();
    hs_cyc.delete();
    exp_q.delete();
    release_reset();
    instr_ready = 1'b1;
    expect_seq(RST_PC, 4);
    @(negedge clk);
    check("ar_restart_req", {31'b0, imem_req}, 32'd1);
    check("ar_restart_addr", imem_addr, RST_PC);
    drain("ar_drain", 60);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_fetch_stage
